// File: rtl/cmd_dispatch_pkg.sv
// Shared opcode constants, FSM state encoding and payload-length helper for
// the host command dispatcher.
package cmd_pkg;

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_TRIG_BASE = 8'h01;
  localparam logic [7:0] OP_WRITE_REG = 8'h40;
  localparam logic [7:0] OP_READ_REG  = 8'h41;

  localparam int unsigned ST_W = 3;

  // Encodings are exported on state_dbg, so they are fixed explicitly.
  typedef enum logic [ST_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_EVAL     = 3'd1,
    ST_ARG      = 3'd2,
    ST_EXEC     = 3'd3,
    ST_READBACK = 3'd4
  } state_t;

  function automatic logic [1:0] payload_len(input logic [7:0] op);
    case (op)
      OP_WRITE_REG: return 2'd2;
      OP_READ_REG:  return 2'd1;
      default:      return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/cmd_dispatch_if.sv
// RX FIFO read port and TX readback handshake between the dispatcher and
// its neighbours.
interface cmd_dispatch_if;

  logic [7:0]  rx_rdata;
  logic        rx_rempty;
  logic        rx_rinc;
  logic [15:0] rd_data;
  logic        rd_avail;
  logic        rd_accept;

  modport master (
    input  rx_rdata, rx_rempty, rd_accept,
    output rx_rinc, rd_data, rd_avail
  );

  modport slave (
    output rx_rdata, rx_rempty, rd_accept,
    input  rx_rinc, rd_data, rd_avail
  );

endinterface

// File: rtl/cmd_dispatch_trig_hold.sv
// Per-channel trigger request holder: set by the decoder, cleared once the
// engine reports busy; a coincident set always wins.
module trig_hold (
  input  logic clk,
  input  logic rst_n,
  input  logic i_set,
  input  logic i_busy,
  output logic o_req
);

  logic r_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req <= 1'b0;
    end else if (i_set) begin
      r_req <= 1'b1;
    end else if (i_busy) begin
      r_req <= 1'b0;
    end
  end

  assign o_req = r_req;

endmodule

// File: rtl/cmd_dispatch.sv
// Host command decoder: pops opcodes/payload from the RX FIFO, raises trigger
// requests, maintains a settings register file and returns readback words.
module cmd_dispatch
  import cmd_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int NUM_REGS = 4,
  parameter int TIMEOUT  = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cmd_dispatch_if.master        bus,
  input  logic [NUM_CH-1:0]     trig_busy,
  output logic [NUM_CH-1:0]     trig_req,
  output logic [NUM_REGS*8-1:0] regs,
  output logic                  err_pulse,
  output logic [7:0]            err_count,
  output logic [ST_W-1:0]       state_dbg
);

  localparam int TW = $clog2(TIMEOUT);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_op;
  logic [7:0]      r_addr;
  logic [7:0]      r_data;
  logic            r_arg_idx;
  logic [TW-1:0]   r_tcnt;
  logic [7:0]      r_regs [NUM_REGS];
  logic [15:0]     r_rd_data;
  logic            r_rd_avail;
  logic            r_err_pulse;
  logic [7:0]      r_err_count;

  logic              w_pop;
  logic              w_cap_op;
  logic              w_cap_arg;
  logic              w_arg_clr;
  logic              w_tcnt_clr;
  logic              w_tcnt_inc;
  logic              w_wr_en;
  logic              w_rd_load;
  logic              w_rd_done;
  logic              w_err;
  logic              w_is_trig;
  logic              w_addr_ok;
  logic [7:0]        w_rd_val;
  logic [NUM_CH-1:0] w_set;
  logic [NUM_CH-1:0] w_trig_req;

  assign w_is_trig = (r_op != OP_NOP) && ({24'd0, r_op} <= $unsigned(NUM_CH));

  // Address decode is a compare loop so any NUM_REGS works with the 8-bit addr.
  always_comb begin
    w_addr_ok = 1'b0;
    w_rd_val  = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_addr == 8'(i)) begin
        w_addr_ok = 1'b1;
        w_rd_val  = r_regs[i];
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_cap_op   = 1'b0;
    w_cap_arg  = 1'b0;
    w_arg_clr  = 1'b0;
    w_tcnt_clr = 1'b0;
    w_tcnt_inc = 1'b0;
    w_wr_en    = 1'b0;
    w_rd_load  = 1'b0;
    w_rd_done  = 1'b0;
    w_err      = 1'b0;
    w_set      = '0;
    case (r_state)
      ST_IDLE: begin
        if (!bus.rx_rempty) begin
          w_pop    = 1'b1;
          w_cap_op = 1'b1;
          w_next   = ST_EVAL;
        end
      end
      ST_EVAL: begin
        w_next = ST_IDLE;
        if (r_op == OP_NOP) begin
          w_next = ST_IDLE;
        end else if (w_is_trig) begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (r_op == 8'(i + 1)) begin
              if (w_trig_req[i]) w_err    = 1'b1;
              else               w_set[i] = 1'b1;
            end
          end
        end else if (r_op == OP_WRITE_REG || r_op == OP_READ_REG) begin
          w_arg_clr = 1'b1;
          w_next    = ST_ARG;
        end else begin
          w_err = 1'b1;
        end
      end
      ST_ARG: begin
        if (!bus.rx_rempty) begin
          w_pop      = 1'b1;
          w_cap_arg  = 1'b1;
          w_tcnt_clr = 1'b1;
          if ({1'b0, r_arg_idx} + 2'd1 == payload_len(r_op)) w_next = ST_EXEC;
        end else if (r_tcnt == TW'(TIMEOUT - 2)) begin
          // This cycle is the (TIMEOUT-1)th consecutive empty one.
          w_err  = 1'b1;
          w_next = ST_IDLE;
        end else begin
          w_tcnt_inc = 1'b1;
        end
      end
      ST_EXEC: begin
        if (r_op == OP_WRITE_REG) begin
          if (w_addr_ok) w_wr_en = 1'b1;
          else           w_err   = 1'b1;
          w_next = ST_IDLE;
        end else begin
          w_rd_load = 1'b1;
          if (!w_addr_ok) w_err = 1'b1;
          w_next = ST_READBACK;
        end
      end
      ST_READBACK: begin
        if (bus.rd_accept) begin
          w_rd_done = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_arg_idx   <= 1'b0;
      r_tcnt      <= '0;
      r_rd_data   <= '0;
      r_rd_avail  <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_next;
      r_err_pulse <= w_err;
      if (w_err) r_err_count <= sat_inc(r_err_count);
      if (w_arg_clr)      r_arg_idx <= 1'b0;
      else if (w_cap_arg) r_arg_idx <= 1'b1;
      if (w_arg_clr || w_tcnt_clr) r_tcnt <= '0;
      else if (w_tcnt_inc)         r_tcnt <= r_tcnt + 1'b1;
      if (w_rd_load) begin
        r_rd_data  <= {r_addr, w_rd_val};
        r_rd_avail <= 1'b1;
      end else if (w_rd_done) begin
        r_rd_avail <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_addr == 8'(i)) r_regs[i] <= r_data;
      end
    end
  end

  // Opcode and payload holding registers need no reset; IDLE never reads them.
  always_ff @(posedge clk) begin
    if (w_cap_op) r_op <= bus.rx_rdata;
    if (w_cap_arg) begin
      if (!r_arg_idx) r_addr <= bus.rx_rdata;
      else            r_data <= bus.rx_rdata;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_trig
    trig_hold u_hold (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_set  (w_set[g]),
      .i_busy (trig_busy[g]),
      .o_req  (w_trig_req[g])
    );
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[8*g +: 8] = r_regs[g];
  end

  assign trig_req    = w_trig_req;
  assign bus.rx_rinc = w_pop;
  assign bus.rd_data = r_rd_data;
  assign bus.rd_avail = r_rd_avail;
  assign err_pulse   = r_err_pulse;
  assign err_count   = r_err_count;
  assign state_dbg   = r_state;

endmodule
